// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encoding, score width default and the
// goal boundaries derived from the screen configuration macros.
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif
`ifndef SCREEN_BORDER
`define SCREEN_BORDER 8
`endif
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef KEYS_W
`define KEYS_W 4
`endif

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int SCORE_W_DEFAULT = 4;
    localparam int X_POS_W         = `X_POS_W;
    localparam int KEYS_W          = `KEYS_W;

    localparam logic [X_POS_W-1:0] GOAL_LEFT_X  = X_POS_W'(`SCREEN_BORDER);
    localparam logic [X_POS_W-1:0] GOAL_RIGHT_X = X_POS_W'(`SCREEN_H_RES);

    // Ball has left through the enemy's (left) side: the player scores.
    function automatic logic is_player_goal(input logic [X_POS_W-1:0] x);
        return (x < GOAL_LEFT_X);
    endfunction

    function automatic logic is_enemy_goal(input logic [X_POS_W-1:0] x);
        return (x > GOAL_RIGHT_X);
    endfunction

endpackage

// File: rtl/score_keeper_frame_timer.sv
// Counts frame strobes and flags the strobe on which the count reaches len_i-1.
module frame_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       new_frame_i,
    input  logic [7:0] len_i,
    output logic       done_o
);

    logic [7:0] count_r;
    logic       at_end_s;

    // done_o is combinational so the owner can act on the very strobe that ends the interval.
    always_comb begin
        at_end_s = (count_r == (len_i - 8'd1));
        done_o   = new_frame_i & at_end_s & ~clear_i;
    end

    // Frame strobe counter, held at zero while cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= 8'd0;
        end else if (clear_i) begin
            count_r <= 8'd0;
        end else if (new_frame_i) begin
            if (at_end_s) begin
                count_r <= 8'd0;
            end else begin
                count_r <= count_r + 8'd1;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Match controller: detects goals once per frame, keeps both scores and
// sequences IDLE -> SERVE -> PLAY -> OVER.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = SCORE_W_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               new_frame_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic [KEYS_W-1:0]  keys_i,
    output logic               game_run_o,
    output logic [1:0]         state_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] enemy_score_o,
    output logic               point_o,
    output logic               winner_o
);

    localparam logic [SCORE_W-1:0] WIN_M1_C    = SCORE_W'(WIN_SCORE - 1);
    localparam logic [SCORE_W-1:0] ONE_C       = SCORE_W'(1);
    localparam logic [7:0]         SERVE_LEN_C = 8'(SERVE_FRAMES);

    game_state_t        state_r;
    logic [SCORE_W-1:0] player_score_r;
    logic [SCORE_W-1:0] enemy_score_r;
    logic               game_run_r;
    logic               point_r;
    logic               winner_r;
    logic               key_prev_r;
    logic               key_armed_r;

    logic key_any_s;
    logic start_s;
    logic player_goal_s;
    logic enemy_goal_s;
    logic timer_clear_s;
    logic serve_done_s;

    // Start edge detect and goal decode; player goal wins if both ever fire.
    always_comb begin
        key_any_s     = |keys_i;
        start_s       = key_any_s & ~key_prev_r & key_armed_r;
        player_goal_s = new_frame_i & (state_r == PLAY) & is_player_goal(ball_x_i);
        enemy_goal_s  = new_frame_i & (state_r == PLAY) & is_enemy_goal(ball_x_i) & ~player_goal_s;
        timer_clear_s = (state_r != SERVE);
    end

    frame_timer u_serve_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (timer_clear_s),
        .new_frame_i (new_frame_i),
        .len_i       (SERVE_LEN_C),
        .done_o      (serve_done_s)
    );

    // Key history; arming requires keys seen released, so a key held through reset cannot start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_prev_r  <= 1'b0;
            key_armed_r <= 1'b0;
        end else begin
            key_prev_r  <= key_any_s;
            key_armed_r <= key_armed_r | ~key_any_s;
        end
    end

    // Match FSM with scores and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            player_score_r <= '0;
            enemy_score_r  <= '0;
            game_run_r     <= 1'b0;
            point_r        <= 1'b0;
            winner_r       <= 1'b0;
        end else begin
            point_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= SERVE;
                    end
                end
                SERVE: begin
                    if (serve_done_s) begin
                        state_r    <= PLAY;
                        game_run_r <= 1'b1;
                    end
                end
                PLAY: begin
                    if (player_goal_s) begin
                        player_score_r <= player_score_r + ONE_C;
                        point_r        <= 1'b1;
                        game_run_r     <= 1'b0;
                        if (player_score_r == WIN_M1_C) begin
                            state_r  <= OVER;
                            winner_r <= 1'b1;
                        end else begin
                            state_r <= SERVE;
                        end
                    end else if (enemy_goal_s) begin
                        enemy_score_r <= enemy_score_r + ONE_C;
                        point_r       <= 1'b1;
                        game_run_r    <= 1'b0;
                        if (enemy_score_r == WIN_M1_C) begin
                            state_r  <= OVER;
                            winner_r <= 1'b0;
                        end else begin
                            state_r <= SERVE;
                        end
                    end
                end
                OVER: begin
                    if (start_s) begin
                        player_score_r <= '0;
                        enemy_score_r  <= '0;
                        winner_r       <= 1'b0;
                        state_r        <= SERVE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    game_run_r <= 1'b0;
                end
            endcase
        end
    end

    assign game_run_o     = game_run_r;
    assign state_o        = state_r;
    assign player_score_o = player_score_r;
    assign enemy_score_o  = enemy_score_r;
    assign point_o        = point_r;
    assign winner_o       = winner_r;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, multi-cycle reset corner cases,
// then random stimulus against a frame-level reference model.
module tb_score_keeper;
    import pong_pkg::*;

    localparam int WIN = 2;
    localparam int SF  = 3;
    localparam int SW  = 4;
    localparam int MID = 320;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              nf  = 1'b0;
    logic [X_POS_W-1:0] bx = X_POS_W'(MID);
    logic [KEYS_W-1:0] keys = '0;
    logic              run, pt, win;
    logic [1:0]        st;
    logic [SW-1:0]     ps, es;

    int checks = 0;
    int errors = 0;

    // reference model state: 0 idle, 1 serve, 2 play, 3 over
    int m_st, m_ps, m_es, m_frames;
    bit m_run, m_pt, m_win, m_kprev, m_seen_low;

    typedef struct {
        bit nf; int bx; int k;
        int st; int ps; int es; bit run; bit pt; bit win;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .SCORE_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .new_frame_i(nf), .ball_x_i(bx), .keys_i(keys),
        .game_run_o(run), .state_o(st), .player_score_o(ps), .enemy_score_o(es),
        .point_o(pt), .winner_o(win)
    );

    function automatic logic [12:0] pack(int s, int p, int e, bit r, bit q, bit w);
        return {2'(s), 4'(p), 4'(e), r, q, w};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {st, ps, es, run, pt, win};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got st/ps/es/run/pt/win=%h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ps = 0; m_es = 0; m_frames = 0;
        m_run = 0; m_pt = 0; m_win = 0; m_kprev = 0; m_seen_low = 0;
    endtask

    task automatic model_step(input bit f, input int x, input int k);
        bit any, start;
        any   = (k != 0);
        start = any && !m_kprev && m_seen_low;
        m_kprev = any;
        if (!any) m_seen_low = 1;
        m_pt = 0;
        case (m_st)
            0: if (start) begin m_st = 1; m_frames = 0; end
            1: if (f) begin
                   m_frames++;
                   if (m_frames == SF) m_st = 2;
               end
            2: if (f && (x < `SCREEN_BORDER || x > `SCREEN_H_RES)) begin
                   m_pt = 1;
                   if (x < `SCREEN_BORDER) m_ps++; else m_es++;
                   if (m_ps == WIN || m_es == WIN) begin
                       m_st = 3; m_win = (m_ps == WIN);
                   end else begin
                       m_st = 1; m_frames = 0;
                   end
               end
            default: if (start) begin
                   m_st = 1; m_frames = 0; m_ps = 0; m_es = 0; m_win = 0;
               end
        endcase
        m_run = (m_st == 2);
    endtask

    task automatic step(input bit f, input int x, input int k);
        nf = f; bx = X_POS_W'(x); keys = KEYS_W'(k);
        @(posedge clk);
        #1;
        model_step(f, x, k);
    endtask

    task automatic add(input bit f, input int x, input int k, input int s, input int p,
                       input int e, input bit r, input bit q, input bit w);
        vec_t v;
        v.nf = f; v.bx = x; v.k = k; v.st = s; v.ps = p; v.es = e; v.run = r; v.pt = q; v.win = w;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_values", dut_vec(), 13'd0);
        rst = 1'b0;

        add(0, MID, 0, 0, 0, 0, 0, 0, 0);
        add(0, MID, 1, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 1, 0, 0, 0, 0, 0);
        add(0, MID, 0, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 2, 0, 0, 1, 0, 0);
        add(0, 0,   0, 2, 0, 0, 1, 0, 0);
        add(1, 0,   0, 1, 1, 0, 0, 1, 0);
        add(1, 0,   0, 1, 1, 0, 0, 0, 0);
        add(1, 0,   0, 1, 1, 0, 0, 0, 0);
        add(1, 0,   0, 2, 1, 0, 1, 0, 0);
        add(0, 641, 1, 2, 1, 0, 1, 0, 0);
        add(1, 641, 1, 1, 1, 1, 0, 1, 0);
        add(1, MID, 0, 1, 1, 1, 0, 0, 0);
        add(0, MID, 1, 1, 1, 1, 0, 0, 0);
        add(1, MID, 0, 1, 1, 1, 0, 0, 0);
        add(1, MID, 0, 2, 1, 1, 1, 0, 0);
        add(1, 0,   1, 3, 2, 1, 0, 1, 1);
        add(1, 0,   1, 3, 2, 1, 0, 0, 1);
        add(0, MID, 1, 3, 2, 1, 0, 0, 1);
        add(0, MID, 0, 3, 2, 1, 0, 0, 1);
        add(1, MID, 1, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 1, 0, 0, 0, 0, 0);
        add(1, MID, 0, 2, 0, 0, 1, 0, 0);
        add(1, 8,   0, 2, 0, 0, 1, 0, 0);
        add(1, 640, 0, 2, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].nf, tbl[i].bx, tbl[i].k);
            check($sformatf("table_row%0d", i), dut_vec(),
                  pack(tbl[i].st, tbl[i].ps, tbl[i].es, tbl[i].run, tbl[i].pt, tbl[i].win));
        end

        // Enemy goal then asynchronous reset in the middle of SERVE, key held across release.
        step(1, 641, 0);
        check("enemy_goal_to_serve", dut_vec(), pack(1, 0, 1, 0, 1, 0));
        keys = 4'h1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_no_clock", dut_vec(), 13'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, MID, 1);
            check("held_key_no_start", dut_vec(), 13'd0);
        end
        step(0, MID, 0);
        step(0, MID, 2);
        check("press_after_reset", dut_vec(), pack(1, 0, 0, 0, 0, 0));

        // Random play against the reference model.
        for (int c = 0; c < 4000; c++) begin
            int r, x, k;
            bit f;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #2;
                check("rand_async_reset", dut_vec(), 13'd0);
                rst = 1'b0;
                model_reset();
            end
            f = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 2)       x = $urandom_range(0, `SCREEN_BORDER - 1);
            else if (r < 4)  x = $urandom_range(`SCREEN_H_RES + 1, 1023);
            else if (r == 4) x = ($urandom_range(0, 1) == 1) ? `SCREEN_BORDER : `SCREEN_H_RES;
            else             x = $urandom_range(`SCREEN_BORDER, `SCREEN_H_RES);
            k = int'(keys);
            if ($urandom_range(0, 11) == 0) k = (k != 0) ? 0 : $urandom_range(1, 15);
            step(f, x, k);
            check("random_vs_model", dut_vec(), pack(m_st, m_ps, m_es, m_run, m_pt, m_win));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
